// File: rtl/pr_encoder_arb_pkg.sv
// rtl/pr_encoder_arb_pkg.sv - shared definitions for the priority encoder/arbiter family
package pr_enc_pkg;

  localparam int PR_DEF_N   = 8;
  localparam int PR_RST_IDX = 0;

  // Index width for n request lines, never narrower than one bit.
  function automatic int pr_idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/pr_encoder_arb_if.sv
// rtl/pr_encoder_arb_if.sv - request/grant bus between sources, arbiter and consumer
interface pr_encoder_arb_if
  import pr_enc_pkg::*;
#(
  parameter int N = PR_DEF_N
) ();

  localparam int IDX_W = pr_idx_w(N);

  logic [N-1:0]     req_i;
  logic [IDX_W-1:0] out_idx_o;
  logic             out_vld_o;
  logic             out_rdy_i;
  logic [N-1:0]     pend_o;
  logic             idle_o;

  modport master (
    input  req_i,
    input  out_rdy_i,
    output out_idx_o,
    output out_vld_o,
    output pend_o,
    output idle_o
  );

  modport slave (
    output req_i,
    output out_rdy_i,
    input  out_idx_o,
    input  out_vld_o,
    input  pend_o,
    input  idle_o
  );

endinterface

// File: rtl/pr_find_hi.sv
// rtl/pr_find_hi.sv - highest set bit at or below start, searching downward modulo N
module pr_find_hi #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] pos;

  // Walk from farthest to nearest so the position closest to start wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = IDX_W'((int'(start) - i + N) % N);
      if (vec[pos]) begin
        idx = pos;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pr_encoder_arb.sv
// rtl/pr_encoder_arb.sv - registered N-way priority encoder with sticky pending bits
// Optional rotating priority: define PR_ENCODER_ARB_ROUND_ROBIN_EN.
module pr_encoder_arb
  import pr_enc_pkg::*;
#(
  parameter int N = PR_DEF_N
) (
  input  logic               clk,
  input  logic               rst_n,
  pr_encoder_arb_if.master   bus
);

  localparam int IDX_W = pr_idx_w(N);

  logic [N-1:0]     pend_q, pend_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_vld_q, out_vld_d;
  logic [N-1:0]     eff;
  logic             free;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] sel;
  logic             sel_any;

  assign eff  = pend_q | bus.req_i;
  assign free = !out_vld_q || bus.out_rdy_i;

`ifdef PR_ENCODER_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Search begins just below the last grant, so the last winner drops to lowest priority.
  assign start = (ptr_q == '0) ? IDX_W'(N - 1) : ptr_q - 1'b1;
`else
  assign start = IDX_W'(N - 1);
`endif

  pr_find_hi #(.N(N), .IDX_W(IDX_W)) u_find (
    .vec   (eff),
    .start (start),
    .idx   (sel),
    .any   (sel_any)
  );

  always_comb begin
    pend_d    = eff;
    out_idx_d = out_idx_q;
    out_vld_d = out_vld_q;
`ifdef PR_ENCODER_ARB_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    if (free) begin
      if (sel_any) begin
        out_idx_d = sel;
        out_vld_d = 1'b1;
        pend_d    = eff & ~(N'(1) << sel);
`ifdef PR_ENCODER_ARB_ROUND_ROBIN_EN
        ptr_d     = sel;
`endif
      end else begin
        out_vld_d = 1'b0;
        pend_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      out_idx_q <= IDX_W'(PR_RST_IDX);
      out_vld_q <= 1'b0;
`ifdef PR_ENCODER_ARB_ROUND_ROBIN_EN
      ptr_q     <= IDX_W'(N - 1);
`endif
    end else begin
      pend_q    <= pend_d;
      out_idx_q <= out_idx_d;
      out_vld_q <= out_vld_d;
`ifdef PR_ENCODER_ARB_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign bus.out_idx_o = out_idx_q;
  assign bus.out_vld_o = out_vld_q;
  assign bus.pend_o    = pend_q;
  assign bus.idle_o    = (pend_q == '0) && !out_vld_q && (bus.req_i == '0);

endmodule

// File: tb/tb_pr_encoder_arb.sv
// tb/tb_pr_encoder_arb.sv - directed vector bench for pr_encoder_arb at N=8, 16 and 3
module tb_pr_encoder_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pr_encoder_arb_if #(.N(8))  b8 ();
  pr_encoder_arb_if #(.N(16)) b16 ();
  pr_encoder_arb_if #(.N(3))  b3 ();

  pr_encoder_arb #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.master));
  pr_encoder_arb #(.N(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.master));
  pr_encoder_arb #(.N(3))  dut3  (.clk(clk), .rst_n(rst_n), .bus(b3.master));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic       vld;
    logic [2:0] idx;
    logic [7:0] pend;
    logic       idle;
  } vec_t;

  vec_t tbl [20];

  logic [31:0] seen;
  int          grants;

  initial begin
    tbl[0]  = '{8'hA5, 1'b1, 1'b1, 3'd7, 8'h25, 1'b0};
    tbl[1]  = '{8'h00, 1'b1, 1'b1, 3'd5, 8'h05, 1'b0};
    tbl[2]  = '{8'h00, 1'b1, 1'b1, 3'd2, 8'h01, 1'b0};
    tbl[3]  = '{8'h00, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0};
    tbl[4]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1};
    tbl[5]  = '{8'h10, 1'b0, 1'b1, 3'd4, 8'h00, 1'b0};
    tbl[6]  = '{8'h80, 1'b0, 1'b1, 3'd4, 8'h80, 1'b0};
    tbl[7]  = '{8'h00, 1'b0, 1'b1, 3'd4, 8'h80, 1'b0};
    tbl[8]  = '{8'h00, 1'b1, 1'b1, 3'd7, 8'h00, 1'b0};
    tbl[9]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1};
    tbl[10] = '{8'h08, 1'b0, 1'b1, 3'd3, 8'h00, 1'b0};
    tbl[11] = '{8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0};
    tbl[12] = '{8'h00, 1'b1, 1'b1, 3'd3, 8'h00, 1'b0};
    tbl[13] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1};
    tbl[14] = '{8'h08, 1'b1, 1'b1, 3'd3, 8'h00, 1'b0};
    tbl[15] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1};
    tbl[16] = '{8'h44, 1'b0, 1'b1, 3'd6, 8'h04, 1'b0};
    tbl[17] = '{8'h04, 1'b0, 1'b1, 3'd6, 8'h04, 1'b0};
    tbl[18] = '{8'h00, 1'b1, 1'b1, 3'd2, 8'h00, 1'b0};
    tbl[19] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1};

    b8.req_i  = '0; b8.out_rdy_i  = 1'b0;
    b16.req_i = '0; b16.out_rdy_i = 1'b0;
    b3.req_i  = '0; b3.out_rdy_i  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld",  32'(b8.out_vld_o), 32'd0);
    chk("rst_idx",  32'(b8.out_idx_o), 32'd0);
    chk("rst_pend", 32'(b8.pend_o),    32'd0);
    chk("rst_idle", 32'(b8.idle_o),    32'd1);
    @(negedge clk) rst_n = 1'b1;

    // Asynchronous reset while a grant is outstanding
    @(negedge clk);
    b8.req_i = 8'hFF;
    b8.out_rdy_i = 1'b0;
    @(posedge clk); #1;
    chk("mid_vld_before", 32'(b8.out_vld_o), 32'd1);
    b8.req_i = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("async_vld",  32'(b8.out_vld_o), 32'd0);
    chk("async_pend", 32'(b8.pend_o),    32'd0);
    chk("async_idle", 32'(b8.idle_o),    32'd1);
    @(negedge clk) rst_n = 1'b1;

`ifndef PR_ENCODER_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      b8.req_i     = tbl[i].req;
      b8.out_rdy_i = tbl[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("v%0d_vld", i),  32'(b8.out_vld_o), 32'(tbl[i].vld));
      if (tbl[i].vld)
        chk($sformatf("v%0d_idx", i), 32'(b8.out_idx_o), 32'(tbl[i].idx));
      chk($sformatf("v%0d_pend", i), 32'(b8.pend_o), 32'(tbl[i].pend));
      chk($sformatf("v%0d_idle", i), 32'(b8.idle_o), 32'(tbl[i].idle));
    end
`else
    // Rotating priority with every source held requesting
    @(negedge clk);
    b8.req_i     = 8'hFF;
    b8.out_rdy_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rr%0d_vld", k), 32'(b8.out_vld_o), 32'd1);
      chk($sformatf("rr%0d_idx", k), 32'(b8.out_idx_o), 32'((6 - k + 16) % 8));
    end
`endif
    @(negedge clk);
    b8.req_i = '0;
    b8.out_rdy_i = 1'b1;
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // N=16 all-ones burst
    @(negedge clk);
    b16.req_i = '1;
    b16.out_rdy_i = 1'b1;
    @(posedge clk); #1;
    b16.req_i = '0;
    seen = '0;
    grants = 0;
    for (int c = 0; c < 20; c++) begin
      if (!b16.out_vld_o) break;
      chk("n16_range", 32'(b16.out_idx_o < 5'd16), 32'd1);
      chk("n16_dup", seen[b16.out_idx_o], 1'b0);
      seen[b16.out_idx_o] = 1'b1;
      grants++;
      @(posedge clk); #1;
    end
    chk("n16_seen",   seen, 32'h0000_FFFF);
    chk("n16_grants", 32'(grants), 32'd16);
    chk("n16_idle",   32'(b16.idle_o), 32'd1);

    // N=3 all-ones burst
    @(negedge clk);
    b3.req_i = '1;
    b3.out_rdy_i = 1'b1;
    @(posedge clk); #1;
    b3.req_i = '0;
    seen = '0;
    grants = 0;
    for (int c = 0; c < 8; c++) begin
      if (!b3.out_vld_o) break;
      chk("n3_range", 32'(b3.out_idx_o < 2'd3), 32'd1);
      chk("n3_dup", seen[b3.out_idx_o], 1'b0);
      seen[b3.out_idx_o] = 1'b1;
      grants++;
      @(posedge clk); #1;
    end
    chk("n3_seen",   seen, 32'h0000_0007);
    chk("n3_grants", 32'(grants), 32'd3);
    chk("n3_idle",   32'(b3.idle_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
